led_frame_sequencer: RTL and testbench

- Upstream feeder for the 24-bit serial LED encoder. Walks a pixel RAM once per frame, one address per LED.
- Presents each colour word, reordered to wire order, on a stable 24-bit bus and pulses a per-pixel restart into the encoder.
- Pixels are sent back-to-back; the next pixel is prefetched while the current one is sent.
- After the last pixel, enforces the strip latch gap and then signals frame completion.

---
 rtl/led_frame_sequencer_if.sv | 28 ++
 rtl/led_frame_sequencer.sv | 146 ++++++++++++++
 tb/tb_led_frame_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/led_frame_sequencer_if.sv
// Pixel RAM read port plus the parallel pixel bus into the serial LED encoder.
interface led_frame_sequencer_if #(
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd_en;
  logic [23:0]           mem_rd_data;
  logic [23:0]           pixel_data;
  logic                  pixel_start;

  // Sequencer side: drives RAM reads and the encoder bus
  modport master (
    output mem_addr,
    output mem_rd_en,
    input  mem_rd_data,
    output pixel_data,
    output pixel_start
  );

  // RAM / encoder side
  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    output mem_rd_data,
    input  pixel_data,
    input  pixel_start
  );
endinterface

// File: rtl/led_frame_sequencer.sv
// Frame sequencer for a serial LED strip: reads one RAM word per LED, reorders it
// to wire order, holds it on the encoder bus for a full pixel time while the next
// word is prefetched, then enforces the strip latch gap before reporting done.
module led_frame_sequencer #(
  parameter int NUM_LEDS         = 60,
  parameter int ADDR_WIDTH       = 6,
  parameter int CLOCKS_PER_PIXEL = 96,
  parameter int LATCH_CYCLES     = 1024,
  parameter int GRB_ORDER        = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic frame_start,
  output logic busy,
  output logic frame_done,
  led_frame_sequencer_if.master bus
);

  localparam int CLK_W = (CLOCKS_PER_PIXEL > 1) ? $clog2(CLOCKS_PER_PIXEL) : 1;
  localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam int PIX_W = ADDR_WIDTH + 1;

  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLOCKS_PER_PIXEL - 1);
  localparam logic [CLK_W-1:0] CLK_CAPT = CLK_W'(1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_LEDS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;

  logic [2:0]            state;
  logic [CLK_W-1:0]      clk_cnt;
  logic [LAT_W-1:0]      lat_cnt;
  logic [PIX_W-1:0]      pixel_cnt;
  logic [PIX_W-1:0]      pix_nxt;
  logic                  more_pix;
  logic [23:0]           shadow_p0;
  logic [23:0]           pix_p1;
  logic                  vld_p1;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // RAM word {R,G,B} to wire order
  function automatic logic [23:0] reorder(input logic [23:0] d);
    if (GRB_ORDER != 0)
      return {d[15:8], d[23:16], d[7:0]};
    else
      return d;
  endfunction

  assign pix_nxt  = pixel_cnt + PIX_W'(1);
  assign more_pix = (pixel_cnt < PIX_LAST);

  // Read strobe: first word in FETCH, then one prefetch at the start of each pixel but the last
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    if (state == S_FETCH) begin
      rd_en = 1'b1;
    end else if (state == S_SEND && clk_cnt == '0 && more_pix) begin
      rd_en   = 1'b1;
      rd_addr = pix_nxt[ADDR_WIDTH-1:0];
    end
  end

  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_addr    = rd_addr;
  assign bus.pixel_data  = pix_p1;
  assign bus.pixel_start = vld_p1;

  // Frame state machine, pixel/latch counters and the two-deep pixel pipeline
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      clk_cnt    <= '0;
      lat_cnt    <= '0;
      pixel_cnt  <= '0;
      shadow_p0  <= '0;
      pix_p1     <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // a request landing on the frame_done cycle is dropped on purpose
          if (frame_start && !frame_done) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          // p0: first word lands in the shadow; p1: bypassed straight onto the bus
          shadow_p0 <= bus.mem_rd_data;
          pix_p1    <= reorder(bus.mem_rd_data);
          vld_p1    <= 1'b1;
          pixel_cnt <= '0;
          clk_cnt   <= '0;
          state     <= S_SEND;
        end
        S_SEND: begin
          // p0: prefetched word arrives one cycle after its read strobe
          if (clk_cnt == CLK_CAPT && more_pix)
            shadow_p0 <= bus.mem_rd_data;
          // p1: swap pixels only at the end of a full pixel time
          if (clk_cnt == CLK_LAST) begin
            if (more_pix) begin
              pix_p1    <= reorder(shadow_p0);
              vld_p1    <= 1'b1;
              pixel_cnt <= pix_nxt;
              clk_cnt   <= '0;
            end else begin
              pix_p1  <= '0;
              lat_cnt <= '0;
              state   <= S_LATCH;
            end
          end else begin
            clk_cnt <= clk_cnt + CLK_W'(1);
          end
        end
        S_LATCH: begin
          if (lat_cnt == LAT_LAST) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench: four sequencer instances (GRB 3 LEDs, RGB 3 LEDs, 1 LED, full
// 2-bit address space) sharing one clock and reset, observed through a selector.
module tb_led_frame_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] fs    = 4'b0;
  logic [3:0] busy_v;
  logic [3:0] fd_v;
  logic [1:0] sel   = 2'd0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clock = ~clock;

  led_frame_sequencer_if #(.ADDR_WIDTH(6)) ifa ();
  led_frame_sequencer_if #(.ADDR_WIDTH(6)) ifb ();
  led_frame_sequencer_if #(.ADDR_WIDTH(6)) ifc ();
  led_frame_sequencer_if #(.ADDR_WIDTH(2)) ifd ();

  led_frame_sequencer #(.NUM_LEDS(3), .ADDR_WIDTH(6), .CLOCKS_PER_PIXEL(96), .LATCH_CYCLES(1024), .GRB_ORDER(1))
    dut_a (.clock(clock), .reset(reset), .frame_start(fs[0]), .busy(busy_v[0]), .frame_done(fd_v[0]), .bus(ifa));
  led_frame_sequencer #(.NUM_LEDS(3), .ADDR_WIDTH(6), .CLOCKS_PER_PIXEL(96), .LATCH_CYCLES(1024), .GRB_ORDER(0))
    dut_b (.clock(clock), .reset(reset), .frame_start(fs[1]), .busy(busy_v[1]), .frame_done(fd_v[1]), .bus(ifb));
  led_frame_sequencer #(.NUM_LEDS(1), .ADDR_WIDTH(6), .CLOCKS_PER_PIXEL(96), .LATCH_CYCLES(1024), .GRB_ORDER(1))
    dut_c (.clock(clock), .reset(reset), .frame_start(fs[2]), .busy(busy_v[2]), .frame_done(fd_v[2]), .bus(ifc));
  led_frame_sequencer #(.NUM_LEDS(4), .ADDR_WIDTH(2), .CLOCKS_PER_PIXEL(96), .LATCH_CYCLES(1024), .GRB_ORDER(1))
    dut_d (.clock(clock), .reset(reset), .frame_start(fs[3]), .busy(busy_v[3]), .frame_done(fd_v[3]), .bus(ifd));

  logic [23:0] ram64 [64];
  logic [23:0] ram4  [4];

  // Synchronous-read RAM models: data valid the cycle after the strobe
  always @(posedge clock) if (ifa.mem_rd_en) ifa.mem_rd_data <= ram64[ifa.mem_addr];
  always @(posedge clock) if (ifb.mem_rd_en) ifb.mem_rd_data <= ram64[ifb.mem_addr];
  always @(posedge clock) if (ifc.mem_rd_en) ifc.mem_rd_data <= ram64[ifc.mem_addr];
  always @(posedge clock) if (ifd.mem_rd_en) ifd.mem_rd_data <= ram4[ifd.mem_addr];

  logic        m_ps, m_rd, m_busy, m_fd, m_fs;
  logic [23:0] m_pd;
  logic [5:0]  m_addr;

  // Route the selected instance to the monitor
  always_comb begin
    m_ps = 1'b0; m_pd = '0; m_rd = 1'b0; m_addr = '0;
    case (sel)
      2'd0: begin m_ps = ifa.pixel_start; m_pd = ifa.pixel_data; m_rd = ifa.mem_rd_en; m_addr = ifa.mem_addr; end
      2'd1: begin m_ps = ifb.pixel_start; m_pd = ifb.pixel_data; m_rd = ifb.mem_rd_en; m_addr = ifb.mem_addr; end
      2'd2: begin m_ps = ifc.pixel_start; m_pd = ifc.pixel_data; m_rd = ifc.mem_rd_en; m_addr = ifc.mem_addr; end
      default: begin m_ps = ifd.pixel_start; m_pd = ifd.pixel_data; m_rd = ifd.mem_rd_en; m_addr = {4'b0, ifd.mem_addr}; end
    endcase
    m_busy = busy_v[sel];
    m_fd   = fd_v[sel];
    m_fs   = fs[sel];
  end

  int          cyc = 0;
  int          n_ps = 0, n_rd = 0, n_fd = 0, busy_cnt = 0, n_bad = 0;
  int          fs_time = 0, fd_time = 0;
  int          ps_time [256];
  logic [23:0] ps_data [256];
  int          rd_addr [256];
  logic [23:0] prev_pd = '0;

  // Event log sampled mid-cycle on the falling edge
  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (m_ps && n_ps < 256) begin
      ps_time[n_ps] <= cyc;
      ps_data[n_ps] <= m_pd;
      n_ps          <= n_ps + 1;
    end
    if (m_rd && n_rd < 256) begin
      rd_addr[n_rd] <= int'(m_addr);
      n_rd          <= n_rd + 1;
    end
    if (m_fd) begin
      fd_time <= cyc;
      n_fd    <= n_fd + 1;
    end
    if (m_busy) busy_cnt <= busy_cnt + 1;
    if (m_fs) fs_time <= cyc;
    if (reset && m_pd != prev_pd && !m_ps && m_pd != 24'h0) n_bad <= n_bad + 1;
    prev_pd <= m_pd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_fs();
    fs[sel] = 1'b1;
    tick(1);
    fs = 4'b0;
  endtask

  logic [23:0] exp_pd [4];

  // One full frame on the selected instance, with optional stray requests mid-frame
  task automatic run_frame(input string tag, input int n, input bit extra);
    int  b_ps, b_rd, b_fd, b_busy, b_bad, t0;
    bit  ok;
    b_ps = n_ps; b_rd = n_rd; b_fd = n_fd; b_busy = busy_cnt; b_bad = n_bad;
    pulse_fs();
    t0 = fs_time;
    if (extra) begin
      tick(150);
      pulse_fs();
      tick(96 * n);
      pulse_fs();
    end
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if (m_fd) begin ok = 1'b1; break; end
    end
    check({tag, " frame_done seen"}, 32'(ok), 32'd1);
    // request coinciding with frame_done must be dropped
    fs[sel] = 1'b1;
    @(posedge clock);
    #1;
    fs = 4'b0;
    tick(5);
    check({tag, " busy after done"}, 32'(m_busy), 32'd0);
    check({tag, " pixel_start count"}, n_ps - b_ps, n);
    check({tag, " read count"}, n_rd - b_rd, n);
    check({tag, " frame_done count"}, n_fd - b_fd, 1);
    check({tag, " busy cycles"}, busy_cnt - b_busy, 2 + 96 * n + 1024);
    check({tag, " data held"}, n_bad - b_bad, 0);
    check({tag, " start latency"}, ps_time[b_ps] - t0, 3);
    check({tag, " latch gap"}, fd_time - ps_time[b_ps + n - 1], 96 + 1024);
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s pixel %0d", tag, k), 32'(ps_data[b_ps + k]), 32'(exp_pd[k]));
      check($sformatf("%s addr %0d", tag, k), rd_addr[b_rd + k], k);
      if (k > 0)
        check($sformatf("%s spacing %0d", tag, k), ps_time[b_ps + k] - ps_time[b_ps + k - 1], 96);
    end
  endtask

  int b_fd_r;

  initial begin
    for (int i = 0; i < 64; i++) ram64[i] = 24'h0;
    ram64[0] = 24'h112233; ram64[1] = 24'h445566; ram64[2] = 24'h778899;
    ram4[0] = 24'hA1B2C3; ram4[1] = 24'h102030; ram4[2] = 24'hFF00FF; ram4[3] = 24'h00FF01;

    tick(3);
    check("reset pixel_data", 32'(ifa.pixel_data), 32'd0);
    check("reset pixel_start", 32'(ifa.pixel_start), 32'd0);
    check("reset mem_rd_en", 32'(ifa.mem_rd_en), 32'd0);
    check("reset busy/done", 32'({busy_v, fd_v}), 32'd0);
    reset = 1'b1;
    tick(2);

    sel = 2'd0;
    exp_pd[0] = 24'h221133; exp_pd[1] = 24'h554466; exp_pd[2] = 24'h887799; exp_pd[3] = 24'h0;
    run_frame("grb3", 3, 1'b1);

    sel = 2'd1;
    exp_pd[0] = 24'h112233; exp_pd[1] = 24'h445566; exp_pd[2] = 24'h778899;
    run_frame("rgb3", 3, 1'b0);

    sel = 2'd2;
    exp_pd[0] = 24'h221133;
    run_frame("one", 1, 1'b0);

    sel = 2'd3;
    exp_pd[0] = 24'hB2A1C3; exp_pd[1] = 24'h201030; exp_pd[2] = 24'h00FFFF; exp_pd[3] = 24'hFF0001;
    run_frame("full", 4, 1'b0);

    // abort during the second pixel
    sel = 2'd0;
    b_fd_r = n_fd;
    pulse_fs();
    tick(3 + 96 + 10);
    check("abort busy before", 32'(busy_v[0]), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort pixel_data", 32'(ifa.pixel_data), 32'd0);
    check("abort mem_rd_en/addr", 32'({ifa.mem_rd_en, ifa.mem_addr}), 32'd0);
    check("abort busy", 32'(busy_v[0]), 32'd0);
    tick(3);
    reset = 1'b1;
    tick(1500);
    check("abort no frame_done", n_fd - b_fd_r, 0);
    exp_pd[0] = 24'h221133; exp_pd[1] = 24'h554466; exp_pd[2] = 24'h887799;
    run_frame("restart", 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
